// File: rtl/uart_cmd_sequencer_if.sv
// uart_cmd_sequencer_if: host byte stream, SPI master and UART transmitter handshakes
// of uart_cmd_sequencer, bundled so the top level can wire them as one port.
interface uart_cmd_sequencer_if;
  logic       i_rx_dv;
  logic [7:0] i_rx_byte;
  logic       o_spi_start;
  logic [7:0] o_spi_upper;
  logic [7:0] o_spi_lower;
  logic       i_spi_busy;
  logic       i_spi_done;
  logic [7:0] i_spi_rx_byte;
  logic       o_tx_dv;
  logic [7:0] o_tx_byte;
  logic       i_tx_active;
  logic       o_sys_reset;
  logic       o_cmd_busy;

  // Sequencer side
  modport master (
    input  i_rx_dv, i_rx_byte, i_spi_busy, i_spi_done, i_spi_rx_byte, i_tx_active,
    output o_spi_start, o_spi_upper, o_spi_lower, o_tx_dv, o_tx_byte, o_sys_reset, o_cmd_busy
  );

  // UART / SPI side
  modport slave (
    output i_rx_dv, i_rx_byte, i_spi_busy, i_spi_done, i_spi_rx_byte, i_tx_active,
    input  o_spi_start, o_spi_upper, o_spi_lower, o_tx_dv, o_tx_byte, o_sys_reset, o_cmd_busy
  );
endinterface

// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer: assembles 3-byte host frames (opcode, addr, data), runs one SPI
// register access or a system-reset pulse, and answers each frame with one UART byte.
// Optional macro CMD_STATUS_EN adds a saturating error counter read back by opcode 's'.
module uart_cmd_sequencer #(
  parameter int unsigned TIMEOUT_CLKS = 5000000,
  parameter int unsigned RESET_CLKS   = 16
) (
  input logic                  i_clock,
  input logic                  i_reset_n,
  uart_cmd_sequencer_if.master bus
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam int unsigned RST_W = $clog2(RESET_CLKS + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CLKS - 1);

  localparam logic [7:0] OP_WRITE = 8'h77;
  localparam logic [7:0] OP_READ  = 8'h72;
  localparam logic [7:0] OP_RESET = 8'h78;
`ifdef CMD_STATUS_EN
  localparam logic [7:0] OP_STATUS = 8'h73;
`endif
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  typedef enum logic [3:0] {
    IDLE, GET_ADDR, GET_DATA, DISPATCH, SPI_LAUNCH, SPI_WAIT, RST_PULSE, RESP, TX_WAIT
  } state_t;

  state_t           state_q, state_nxt;
  logic [7:0]       opcode_q, opcode_nxt;
  logic [7:0]       addr_q, addr_nxt;
  logic [7:0]       data_q, data_nxt;
  logic [7:0]       resp_q, resp_nxt;
  logic [TMO_W-1:0] tmo_q, tmo_nxt;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_nxt;
  logic             spi_start_q, spi_start_nxt;
  logic [7:0]       spi_upper_q, spi_upper_nxt;
  logic [7:0]       spi_lower_q, spi_lower_nxt;
  logic             tx_dv_q, tx_dv_nxt;
  logic [7:0]       tx_byte_q, tx_byte_nxt;
  logic             sys_reset_q, sys_reset_nxt;
  logic             cmd_busy_q, cmd_busy_nxt;

`ifdef CMD_STATUS_EN
  logic [7:0] err_q, err_nxt;
  logic [1:0] err_inc;
  logic       err_clr;
`endif

  // State and registered outputs
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      opcode_q    <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      resp_q      <= '0;
      tmo_q       <= '0;
      rst_cnt_q   <= '0;
      spi_start_q <= 1'b0;
      spi_upper_q <= '0;
      spi_lower_q <= '0;
      tx_dv_q     <= 1'b0;
      tx_byte_q   <= '0;
      sys_reset_q <= 1'b0;
      cmd_busy_q  <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      opcode_q    <= opcode_nxt;
      addr_q      <= addr_nxt;
      data_q      <= data_nxt;
      resp_q      <= resp_nxt;
      tmo_q       <= tmo_nxt;
      rst_cnt_q   <= rst_cnt_nxt;
      spi_start_q <= spi_start_nxt;
      spi_upper_q <= spi_upper_nxt;
      spi_lower_q <= spi_lower_nxt;
      tx_dv_q     <= tx_dv_nxt;
      tx_byte_q   <= tx_byte_nxt;
      sys_reset_q <= sys_reset_nxt;
      cmd_busy_q  <= cmd_busy_nxt;
    end
  end

  // Next-state and next-output decode; strobes default low, data registers hold
  always_comb begin
    state_nxt     = state_q;
    opcode_nxt    = opcode_q;
    addr_nxt      = addr_q;
    data_nxt      = data_q;
    resp_nxt      = resp_q;
    tmo_nxt       = '0;
    rst_cnt_nxt   = rst_cnt_q;
    spi_start_nxt = 1'b0;
    spi_upper_nxt = spi_upper_q;
    spi_lower_nxt = spi_lower_q;
    tx_dv_nxt     = 1'b0;
    tx_byte_nxt   = tx_byte_q;
    sys_reset_nxt = sys_reset_q;

    case (state_q)
      IDLE: begin
        if (bus.i_rx_dv) begin
          opcode_nxt = bus.i_rx_byte;
          state_nxt  = GET_ADDR;
        end
      end
      GET_ADDR: begin
        if (bus.i_rx_dv) begin
          addr_nxt  = bus.i_rx_byte;
          state_nxt = GET_DATA;
        end else if (tmo_q == TMO_LAST) begin
          state_nxt = IDLE;
        end else begin
          tmo_nxt = tmo_q + TMO_W'(1);
        end
      end
      GET_DATA: begin
        if (bus.i_rx_dv) begin
          data_nxt  = bus.i_rx_byte;
          state_nxt = DISPATCH;
        end else if (tmo_q == TMO_LAST) begin
          state_nxt = IDLE;
        end else begin
          tmo_nxt = tmo_q + TMO_W'(1);
        end
      end
      DISPATCH: begin
        case (opcode_q)
          OP_WRITE: begin
            resp_nxt  = RSP_ACK;
            state_nxt = SPI_LAUNCH;
          end
          OP_READ: begin
            state_nxt = SPI_LAUNCH;
          end
          OP_RESET: begin
            resp_nxt      = RSP_ACK;
            sys_reset_nxt = 1'b1;
            rst_cnt_nxt   = '0;
            state_nxt     = RST_PULSE;
          end
`ifdef CMD_STATUS_EN
          OP_STATUS: begin
            resp_nxt  = err_q;
            state_nxt = RESP;
          end
`endif
          default: begin
            resp_nxt  = RSP_NAK;
            state_nxt = RESP;
          end
        endcase
      end
      SPI_LAUNCH: begin
        if (!bus.i_spi_busy) begin
          spi_start_nxt = 1'b1;
          if (opcode_q == OP_READ) begin
            spi_upper_nxt = addr_q | 8'h80;
            spi_lower_nxt = 8'h00;
          end else begin
            spi_upper_nxt = addr_q & 8'h7F;
            spi_lower_nxt = data_q;
          end
          state_nxt = SPI_WAIT;
        end
      end
      SPI_WAIT: begin
        if (bus.i_spi_done) begin
          if (opcode_q == OP_READ) begin
            resp_nxt = bus.i_spi_rx_byte;
          end
          state_nxt = RESP;
        end
      end
      RST_PULSE: begin
        if (rst_cnt_q == RST_LAST) begin
          sys_reset_nxt = 1'b0;
          state_nxt     = RESP;
        end else begin
          rst_cnt_nxt = rst_cnt_q + RST_W'(1);
        end
      end
      RESP: begin
        if (!bus.i_tx_active) begin
          tx_dv_nxt   = 1'b1;
          tx_byte_nxt = resp_q;
          state_nxt   = TX_WAIT;
        end
      end
      TX_WAIT: begin
        // tx_dv_q marks the first TX_WAIT cycle, before uart_tx has raised active
        if (!tx_dv_q && !bus.i_tx_active) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    cmd_busy_nxt = (state_nxt != IDLE);
  end

`ifdef CMD_STATUS_EN
  // Error events: dropped byte, frame timeout, NAK'd opcode; a status read clears and wins
  always_comb begin
    err_inc = '0;
    err_clr = 1'b0;
    if (bus.i_rx_dv && (state_q inside {DISPATCH, SPI_LAUNCH, SPI_WAIT, RST_PULSE, RESP, TX_WAIT})) begin
      err_inc = err_inc + 2'd1;
    end
    if ((state_q inside {GET_ADDR, GET_DATA}) && !bus.i_rx_dv && (tmo_q == TMO_LAST)) begin
      err_inc = err_inc + 2'd1;
    end
    if (state_q == DISPATCH) begin
      if (opcode_q == OP_STATUS) begin
        err_clr = 1'b1;
      end else if (!(opcode_q inside {OP_WRITE, OP_READ, OP_RESET})) begin
        err_inc = err_inc + 2'd1;
      end
    end
    if (err_clr) begin
      err_nxt = '0;
    end else if ((9'(err_q) + 9'(err_inc)) > 9'h0FF) begin
      err_nxt = 8'hFF;
    end else begin
      err_nxt = err_q + 8'(err_inc);
    end
  end

  // Error counter register
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      err_q <= '0;
    end else begin
      err_q <= err_nxt;
    end
  end
`endif

  assign bus.o_spi_start = spi_start_q;
  assign bus.o_spi_upper = spi_upper_q;
  assign bus.o_spi_lower = spi_lower_q;
  assign bus.o_tx_dv     = tx_dv_q;
  assign bus.o_tx_byte   = tx_byte_q;
  assign bus.o_sys_reset = sys_reset_q;
  assign bus.o_cmd_busy  = cmd_busy_q;

endmodule
